// File: rtl/pll_lock_seq.sv
// PLL start-up / recovery sequencer: hold PLL in reset, wait for lock with timeout,
// require stable lock before releasing sys_reset. Define PLL_SEQ_FAULT_EN to enable the FAULT state.
module pll_lock_seq #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRY           = 4
) (
  input  logic       clk,
  input  logic       s_reset_n,
  input  logic       pll_locked,
  input  logic       ext_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic [2:0] state,
  output logic [2:0] retry_cnt,
  output logic       lock_lost,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam int CNT_MAX_A = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  if (RST_HOLD_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 4 || STABLE_CYCLES < 1 || MAX_RETRY < 1)
  begin : g_param_check
    $error("pll_lock_seq: cycle parameter out of range");
  end

  logic             lock_s1_q, lock_s2_q;
  logic             req_s1_q, req_s2_q;
  logic             locked_s, req_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             lost_q, lost_d;

  assign locked_s = lock_s2_q;
  assign req_s    = req_s2_q;

`ifdef PLL_SEQ_FAULT_EN
  logic fault_q;
  logic retry_at_limit;
  assign retry_at_limit = ({29'd0, retry_q} + 32'd1) == 32'(MAX_RETRY);
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    if (req_s) begin
      state_d = ST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (locked_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
            state_d = ST_HOLD;
`ifdef PLL_SEQ_FAULT_EN
            if (retry_at_limit) state_d = ST_FAULT;
`endif
          end
        end
        ST_STABLE: begin
          // A lock dropout restarts the stability window without counting as a failed attempt.
          if (!locked_s) begin
            state_d = ST_WAIT;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_HOLD;
            lost_d  = 1'b1;
          end
        end
`ifdef PLL_SEQ_FAULT_EN
        ST_FAULT: state_d = ST_FAULT;
`endif
        default: state_d = ST_HOLD;
      endcase
    end

    // RUN and FAULT have no terminal count, so the counter parks at zero there.
    if (req_s || (state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
    sys_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      req_s1_q    <= 1'b0;
      req_s2_q    <= 1'b0;
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      lost_q      <= 1'b0;
    end else begin
      lock_s1_q   <= pll_locked;
      lock_s2_q   <= lock_s1_q;
      req_s1_q    <= ext_req;
      req_s2_q    <= req_s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      lost_q      <= lost_d;
    end
  end

`ifdef PLL_SEQ_FAULT_EN
  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == ST_FAULT);
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign pll_reset = pll_reset_q;
  assign sys_reset = sys_reset_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with short cycle parameters; the timeout section
// follows whichever PLL_SEQ_FAULT_EN build is compiled.
module tb_pll_lock_seq;

  logic       clk = 1'b0;
  logic       s_reset_n;
  logic       pll_locked;
  logic       ext_req;
  logic       pll_reset;
  logic       sys_reset;
  logic [2:0] state;
  logic [2:0] retry_cnt;
  logic       lock_lost;
  logic       fault;

  int errors = 0;
  int checks = 0;
  int n;
  logic [2:0] exp_q[$];

  pll_lock_seq #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .STABLE_CYCLES      (8),
    .MAX_RETRY          (2)
  ) dut (
    .clk       (clk),
    .s_reset_n (s_reset_n),
    .pll_locked(pll_locked),
    .ext_req   (ext_req),
    .pll_reset (pll_reset),
    .sys_reset (sys_reset),
    .state     (state),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic ticks_until_pll_low(output int cnt);
    cnt = 0;
    while (pll_reset === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic ticks_until_sys_low(output int cnt);
    cnt = 0;
    while (sys_reset === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    s_reset_n  = 1'b0;
    pll_locked = 1'b0;
    ext_req    = 1'b0;
    ticks(3);
    chk("rst_state", state, 0);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_sys_reset", sys_reset, 1);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_fault", fault, 0);

    // Normal bring-up
    s_reset_n = 1'b1;
    ticks_until_pll_low(n);
    chk("bringup_pll_reset_len", n, 4);
    chk("bringup_wait_state", state, 1);
    ticks(6);
    pll_locked = 1'b1;
    ticks_until_sys_low(n);
    chk("bringup_lock_to_release", n, 11);
    chk("bringup_run_state", state, 3);
    chk("bringup_retry", retry_cnt, 0);

    // Lock loss in RUN, then full re-sequence
    ticks(2);
    chk("run_no_lost", lock_lost, 0);
    pll_locked = 1'b0;
    ticks(2);
    chk("loss_still_run", state, 3);
    chk("loss_not_yet", lock_lost, 0);
    tick();
    chk("loss_pulse", lock_lost, 1);
    chk("loss_state_hold", state, 0);
    chk("loss_sys_reset", sys_reset, 1);
    chk("loss_pll_reset", pll_reset, 1);
    chk("loss_retry", retry_cnt, 0);
    tick();
    chk("loss_pulse_end", lock_lost, 0);
    pll_locked = 1'b1;
    ticks_until_sys_low(n);
    chk("reseq_to_release", n, 12);
    chk("reseq_run_state", state, 3);

    // ext_req pulse from RUN, then glitch in STABLE
    ext_req = 1'b1;
    tick();
    ext_req = 1'b0;
    ticks(2);
    chk("req_hold_state", state, 0);
    chk("req_sys_reset", sys_reset, 1);
    ticks(5);
    chk("glitch_in_stable", state, 2);
    ticks(5);
    pll_locked = 1'b0;
    ticks(2);
    chk("glitch_still_stable", state, 2);
    chk("glitch_sys_held", sys_reset, 1);
    tick();
    chk("glitch_back_wait", state, 1);
    chk("glitch_retry", retry_cnt, 0);
    chk("glitch_sys_reset", sys_reset, 1);
    pll_locked = 1'b1;
    ticks_until_sys_low(n);
    chk("glitch_fresh_stable", n, 11);

    // Lose lock, one timed-out attempt, then sync reset mid-WAIT
    pll_locked = 1'b0;
    ticks(3);
    chk("loss2_pulse", lock_lost, 1);
    ticks(23);
    chk("att1_wait_end", state, 1);
    chk("att1_retry_before", retry_cnt, 0);
    tick();
    chk("att1_timeout_hold", state, 0);
    chk("att1_retry", retry_cnt, 1);
    chk("att1_pll_reset", pll_reset, 1);
    ticks(4);
    chk("att2_wait", state, 1);
    ticks(12);
    s_reset_n = 1'b0;
    tick();
    chk("midrst_state", state, 0);
    chk("midrst_pll_reset", pll_reset, 1);
    chk("midrst_retry", retry_cnt, 0);
    chk("midrst_sys_reset", sys_reset, 1);
    s_reset_n = 1'b1;
    ticks_until_pll_low(n);
    chk("midrst_hold_len", n, 4);

    // Timeouts with lock held low
    ticks(19);
    chk("to1_wait", state, 1);
    tick();
    chk("to1_hold", state, 0);
    chk("to1_retry", retry_cnt, 1);
    chk("to1_fault", fault, 0);
    ticks(4);
    chk("to2_wait_start", state, 1);
    ticks(19);
    chk("to2_wait_end", state, 1);
    tick();
`ifdef PLL_SEQ_FAULT_EN
    chk("fault_state", state, 4);
    chk("fault_flag", fault, 1);
    chk("fault_retry", retry_cnt, 2);
    chk("fault_pll_reset", pll_reset, 1);
    chk("fault_sys_reset", sys_reset, 1);
    ticks(30);
    chk("fault_sticky", state, 4);
    ext_req = 1'b1;
    tick();
    ext_req = 1'b0;
    tick();
    chk("fault_req_latency", state, 4);
    tick();
    chk("fault_exit_state", state, 0);
    chk("fault_exit_retry", retry_cnt, 0);
    chk("fault_exit_flag", fault, 0);
    chk("fault_exit_pll_reset", pll_reset, 1);
`else
    chk("nofault_state", state, 0);
    chk("nofault_retry", retry_cnt, 2);
    chk("nofault_flag", fault, 0);
    chk("nofault_pll_reset", pll_reset, 1);
    for (int k = 3; k <= 8; k++) begin
      exp_q.push_back((k > 7) ? 3'd7 : 3'(k));
      ticks(24);
      chk("retry_sat", retry_cnt, exp_q.pop_front());
      chk("retry_state", state, 0);
      chk("retry_fault", fault, 0);
    end
`endif

    // ext_req held high keeps HOLD with the counter parked
    ext_req = 1'b1;
    ticks(3);
    chk("reqhold_state", state, 0);
    chk("reqhold_retry", retry_cnt, 0);
    ticks(7);
    chk("reqhold_still", state, 0);
    chk("reqhold_pll_reset", pll_reset, 1);
    ext_req = 1'b0;
    ticks_until_pll_low(n);
    chk("reqhold_release_len", n, 6);
    chk("reqhold_wait", state, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
